// File: rtl/lvt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lvt_pkg
// Description : Shared constants and helpers for the LVT multi-port RAM.
//               Holds the read-during-write mode encodings and the LVT
//               index width helper. The LVT index typedef depends on
//               WPORTS, so it is declared in the top from lvt_clog2_min1().
// Revision    : 1.0 - initial release
// ============================================================================
package lvt_pkg;

  // Read-during-write mode encodings for the WRITE_FIRST parameter
  localparam int c_mode_read_first  = 0;
  localparam int c_mode_write_first = 1;

  // Widest LVT index the block supports (16 write ports)
  localparam int c_lvt_max_idx_w = 4;

  // Width of an LVT entry. A single write port still gets a 1-bit entry,
  // so the index type is never zero-width.
  function automatic int lvt_clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : lvt_pkg
`default_nettype wire

// File: rtl/lvt_bank.sv
`default_nettype none
// ============================================================================
// Module      : lvt_bank
// Description : Simple 1W1R RAM with registered read and no reset, written
//               so it maps onto a block RAM. A read of the address being
//               written in the same cycle returns the old contents.
// Ports       : clk      - clock
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_re     - read enable (output register only updates on it)
//               i_raddr  - read address
//               o_rdata  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module lvt_bank #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : lvt_bank
`default_nettype wire

// File: rtl/lvt_multiport_ram.sv
`default_nettype none
// ============================================================================
// Module      : lvt_multiport_ram
// Description : WPORTS-write / RPORTS-read RAM built from a WPORTS x RPORTS
//               grid of 1W1R banks plus a Live Value Table recording which
//               write port last wrote each address. Reads have one cycle of
//               latency; WRITE_FIRST selects old/new data on a same-cycle
//               read of an address being written.
// Ports       : clk       - clock, all state on rising edge
//               rst_n     - asynchronous active-low reset
//               i_wen     - per-port write enable
//               i_waddr   - per-port write address
//               i_wdata   - per-port write data
//               i_ren     - per-port read enable
//               i_raddr   - per-port read address
//               o_rdata   - per-port read data (one cycle after i_ren)
//               o_rvalid  - per-port read valid
// Revision    : 1.0 - initial release
// ============================================================================
module lvt_multiport_ram
  import lvt_pkg::*;
#(
  parameter  int WIDTH       = 32,
  parameter  int DEPTH       = 512,
  parameter  int WPORTS      = 4,
  parameter  int RPORTS      = 4,
  parameter  int WRITE_FIRST = 0,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wen    [WPORTS],
  input  logic [AW-1:0]    i_waddr  [WPORTS],
  input  logic [WIDTH-1:0] i_wdata  [WPORTS],
  input  logic             i_ren    [RPORTS],
  input  logic [AW-1:0]    i_raddr  [RPORTS],
  output logic [WIDTH-1:0] o_rdata  [RPORTS],
  output logic             o_rvalid [RPORTS]
);

  localparam int LW          = lvt_clog2_min1(WPORTS);
  localparam bit C_BYPASS_EN = (WRITE_FIRST == c_mode_write_first);

  typedef logic [LW-1:0] lvt_idx_t;

  lvt_idx_t         r_lvt      [DEPTH];
  logic             w_lvt_we   [WPORTS];
  logic [WIDTH-1:0] w_bank_q   [WPORTS][RPORTS];

  lvt_idx_t         r_sel      [RPORTS];
  logic             r_loaded   [RPORTS];
  logic             r_rvalid   [RPORTS];
  logic             r_byp_hit  [RPORTS];
  logic [WIDTH-1:0] r_byp_data [RPORTS];
  logic             w_byp_hit  [RPORTS];
  logic [WIDTH-1:0] w_byp_data [RPORTS];
  logic [WIDTH-1:0] w_mux_q    [RPORTS];

  // --------------------------------------------------------------------------
  // Bank grid: bank[w][r] is written only by write port w, read only by r
  // --------------------------------------------------------------------------
  generate
    for (genvar gw = 0; gw < WPORTS; gw++) begin : g_wport
      for (genvar gr = 0; gr < RPORTS; gr++) begin : g_rport
        lvt_bank #(
          .WIDTH (WIDTH),
          .DEPTH (DEPTH)
        ) u_bank (
          .clk     (clk),
          .i_we    (i_wen[gw]),
          .i_waddr (i_waddr[gw]),
          .i_wdata (i_wdata[gw]),
          .i_re    (i_ren[gr]),
          .i_raddr (i_raddr[gr]),
          .o_rdata (w_bank_q[gw][gr])
        );
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Conflict priority: a write port only updates the LVT if no higher-index
  // port writes the same address this cycle. Lower ports still fill their
  // own banks; those copies are simply never selected.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int w = 0; w < WPORTS; w++) begin
      w_lvt_we[w] = i_wen[w];
      for (int v = 0; v < WPORTS; v++) begin
        if ((v > w) && i_wen[v] && (i_waddr[v] == i_waddr[w])) begin
          w_lvt_we[w] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) begin
        r_lvt[a] <= '0;
      end
    end else begin
      for (int w = 0; w < WPORTS; w++) begin
        if (w_lvt_we[w]) begin
          r_lvt[i_waddr[w]] <= lvt_idx_t'(w);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Write-first bypass: winning same-cycle write to the read address.
  // Forced inactive in read-first mode so the banks' old data is returned.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int r = 0; r < RPORTS; r++) begin
      w_byp_hit[r]  = 1'b0;
      w_byp_data[r] = '0;
      for (int w = 0; w < WPORTS; w++) begin
        if (C_BYPASS_EN && i_wen[w] && (i_waddr[w] == i_raddr[r])) begin
          w_byp_hit[r]  = 1'b1;
          w_byp_data[r] = i_wdata[w];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read side: the LVT is looked up in the same cycle the banks are read so
  // selector and bank data describe the same (pre-write) memory state.
  // Everything but rvalid only moves on i_ren, so rdata holds when idle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < RPORTS; r++) begin
        r_rvalid[r]   <= 1'b0;
        r_loaded[r]   <= 1'b0;
        r_sel[r]      <= '0;
        r_byp_hit[r]  <= 1'b0;
        r_byp_data[r] <= '0;
      end
    end else begin
      for (int r = 0; r < RPORTS; r++) begin
        r_rvalid[r] <= i_ren[r];
        if (i_ren[r]) begin
          r_loaded[r]   <= 1'b1;
          r_sel[r]      <= r_lvt[i_raddr[r]];
          r_byp_hit[r]  <= w_byp_hit[r];
          r_byp_data[r] <= w_byp_data[r];
        end
      end
    end
  end

  // Output mux. r_loaded keeps rdata at zero after reset until a fresh read
  // lands, since the bank output registers themselves are never reset.
  always_comb begin
    for (int r = 0; r < RPORTS; r++) begin
      w_mux_q[r] = '0;
      for (int w = 0; w < WPORTS; w++) begin
        if (r_sel[r] == lvt_idx_t'(w)) begin
          w_mux_q[r] = w_bank_q[w][r];
        end
      end
      if (!r_loaded[r]) begin
        o_rdata[r] = '0;
      end else if (r_byp_hit[r]) begin
        o_rdata[r] = r_byp_data[r];
      end else begin
        o_rdata[r] = w_mux_q[r];
      end
      o_rvalid[r] = r_rvalid[r];
    end
  end

endmodule : lvt_multiport_ram
`default_nettype wire
